// File: rtl/neural_layer_seq.sv
// neural_layer_seq: serial-load N_IN x N_NEU neural layer evaluated on one shared MAC unit.
// Defining RELU_EN adds the relu_out port carrying the saturated ReLU value of each neuron.
module neural_layer_seq #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_NEU = 4,
   parameter int unsigned DW    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                data_valid,
   input  logic                changes,
   input  logic [DW-1:0]       data_in,
   output logic [N_NEU-1:0]    final_output,
   output logic                out_valid,
   output logic                busy
`ifdef RELU_EN
   ,
   output logic [N_NEU*DW-1:0] relu_out
`endif
);

   localparam int unsigned ACC_W = 2*DW + $clog2(N_IN+1) + 1;
   localparam int unsigned IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int unsigned NW    = (N_NEU > 1) ? $clog2(N_NEU) : 1;
   localparam int unsigned XCW   = $clog2(N_IN+1);
   localparam int unsigned FW    = $clog2(N_IN+2);

   typedef enum logic [1:0] {S_LOAD_X, S_LOAD_W, S_COMPUTE, S_DONE} state_t;

   state_t             r_state;
   logic [DW-1:0]      r_x  [N_IN];
   logic [DW-1:0]      r_th [N_NEU];
   logic [DW-1:0]      r_b  [N_NEU];
   logic [DW-1:0]      r_w  [N_NEU][N_IN];
   logic [XCW-1:0]     r_xcnt;
   logic [FW-1:0]      r_fld;
   logic [NW-1:0]      r_lneu;
   logic               r_wfull;
   logic [NW-1:0]      r_cneu;
   logic [FW-1:0]      r_step;
   logic [ACC_W-1:0]   r_acc;
   logic [N_NEU-1:0]   r_res;
`ifdef RELU_EN
   localparam logic [ACC_W-1:0] DMAX = ACC_W'({DW{1'b1}});
   logic [DW-1:0]      r_relu [N_NEU];
`endif

   logic [IW-1:0]      w_xidx;
   logic [NW-1:0]      w_lneu;
   logic [IW-1:0]      w_widx;
   logic [IW-1:0]      w_cidx;
   logic [ACC_W-1:0]   w_prod;
   logic               w_gt;

   // Load order runs from the top index downward; compute walks inputs upward.
   assign w_xidx = IW'(N_IN-1) - IW'(r_xcnt);
   assign w_lneu = NW'(N_NEU-1) - r_lneu;
   assign w_widx = IW'(N_IN + 1 - 32'(r_fld));
   assign w_cidx = IW'(32'(r_step) - 1);
   assign w_prod = ACC_W'(r_w[r_cneu][w_cidx]) * ACC_W'(r_x[w_cidx]);
   assign w_gt   = r_acc > ACC_W'(r_th[r_cneu]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_LOAD_X;
         final_output <= '0;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
         r_xcnt       <= '0;
         r_fld        <= '0;
         r_lneu       <= '0;
         r_wfull      <= 1'b0;
         r_cneu       <= '0;
         r_step       <= '0;
         r_acc        <= '0;
         r_res        <= '0;
         for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
         for (int j = 0; j < N_NEU; j++) begin
            r_th[j] <= '0;
            r_b[j]  <= '0;
            for (int i = 0; i < N_IN; i++) r_w[j][i] <= '0;
         end
`ifdef RELU_EN
         relu_out <= '0;
         for (int j = 0; j < N_NEU; j++) r_relu[j] <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (r_state)
            S_LOAD_X: begin
               if (data_valid && (r_xcnt < XCW'(N_IN))) begin
                  r_x[w_xidx] <= data_in;
                  r_xcnt      <= r_xcnt + XCW'(1);
               end
               if (changes) begin
                  r_state <= S_LOAD_W;
                  r_xcnt  <= '0;
                  r_fld   <= '0;
                  r_lneu  <= '0;
                  r_wfull <= 1'b0;
               end
            end
            S_LOAD_W: begin
               // Per neuron: th, b, then weights from the highest index down.
               if (data_valid && !r_wfull) begin
                  if (r_fld == '0)            r_th[w_lneu] <= data_in;
                  else if (r_fld == FW'(1))   r_b[w_lneu]  <= data_in;
                  else                        r_w[w_lneu][w_widx] <= data_in;
                  if (r_fld == FW'(N_IN+1)) begin
                     r_fld <= '0;
                     if (r_lneu == NW'(N_NEU-1)) r_wfull <= 1'b1;
                     else                        r_lneu  <= r_lneu + NW'(1);
                  end else begin
                     r_fld <= r_fld + FW'(1);
                  end
               end
               if (changes) begin
                  r_state <= S_COMPUTE;
                  busy    <= 1'b1;
                  r_cneu  <= '0;
                  r_step  <= '0;
               end
            end
            S_COMPUTE: begin
               if (r_step == '0) begin
                  r_acc <= ACC_W'(r_b[r_cneu]);
               end else if (r_step <= FW'(N_IN)) begin
                  r_acc <= r_acc + w_prod;
               end else begin
                  r_res[r_cneu] <= w_gt;
`ifdef RELU_EN
                  r_relu[r_cneu] <= !w_gt ? '0 :
                                    (r_acc > DMAX) ? {DW{1'b1}} : r_acc[DW-1:0];
`endif
               end
               if (r_step == FW'(N_IN+1)) begin
                  r_step <= '0;
                  if (r_cneu == NW'(N_NEU-1)) begin
                     r_state <= S_DONE;
                     busy    <= 1'b0;
                  end else begin
                     r_cneu <= r_cneu + NW'(1);
                  end
               end else begin
                  r_step <= r_step + FW'(1);
               end
            end
            S_DONE: begin
               final_output <= r_res;
               out_valid    <= 1'b1;
               r_state      <= S_LOAD_X;
`ifdef RELU_EN
               for (int j = 0; j < N_NEU; j++) relu_out[j*DW +: DW] <= r_relu[j];
`endif
            end
            default: r_state <= S_LOAD_X;
         endcase
      end
   end

endmodule

// File: tb/tb_neural_layer_seq.sv
// Bench for neural_layer_seq: directed frames plus randomized frames against an arithmetic model.
// A second instance covers the N_IN=3, N_NEU=2, DW=4 configuration.
module tb_neural_layer_seq;

   localparam int NI     = 4;
   localparam int NN     = 4;
   localparam int DW     = 8;
   localparam int NWORDS = NN*(NI+2);
   localparam int LAT    = NWORDS + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset, data_valid, changes;
   logic [DW-1:0]  data_in;
   logic [NN-1:0]  final_output;
   logic           out_valid, busy;
`ifdef RELU_EN
   logic [NN*DW-1:0] relu_out;
`endif

   logic           reset2, dv2, ch2;
   logic [3:0]     din2;
   logic [1:0]     fo2;
   logic           ov2, busy2;
`ifdef RELU_EN
   logic [7:0]     relu2;
`endif

   neural_layer_seq #(.N_IN(NI), .N_NEU(NN), .DW(DW)) u_dut (
      .clk(clk), .reset(reset), .data_valid(data_valid), .changes(changes),
      .data_in(data_in), .final_output(final_output), .out_valid(out_valid), .busy(busy)
`ifdef RELU_EN
      , .relu_out(relu_out)
`endif
   );

   neural_layer_seq #(.N_IN(3), .N_NEU(2), .DW(4)) u_dut2 (
      .clk(clk), .reset(reset2), .data_valid(dv2), .changes(ch2),
      .data_in(din2), .final_output(fo2), .out_valid(ov2), .busy(busy2)
`ifdef RELU_EN
      , .relu_out(relu2)
`endif
   );

   int n_total = 0;
   int n_bad   = 0;
   int m_x  [NI];
   int m_th [NN];
   int m_b  [NN];
   int m_w  [NN][NI];
   int q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NI; i++) m_x[i] = 0;
      for (int j = 0; j < NN; j++) begin
         m_th[j] = 0;
         m_b[j]  = 0;
         for (int i = 0; i < NI; i++) m_w[j][i] = 0;
      end
   endtask

   // Expected outputs straight from the layer equations.
   task automatic model_eval(output logic [NN-1:0] fo, output logic [NN*DW-1:0] ro);
      longint acc;
      fo = '0;
      ro = '0;
      for (int j = 0; j < NN; j++) begin
         acc = m_b[j];
         for (int i = 0; i < NI; i++) acc += longint'(m_w[j][i]) * longint'(m_x[i]);
         fo[j] = (acc > m_th[j]);
         if (acc > m_th[j]) ro[j*DW +: DW] = (acc > 255) ? DW'(255) : DW'(acc);
      end
   endtask

   task automatic put(input int w, input bit gaps, input bit with_ch);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            data_valid = 1'b0;
            data_in    = DW'($urandom);
            tick();
         end
      end
      data_valid = 1'b1;
      data_in    = DW'(w);
      changes    = with_ch;
      tick();
      data_valid = 1'b0;
      changes    = 1'b0;
   endtask

   task automatic pulse_changes();
      changes = 1'b1;
      tick();
      changes = 1'b0;
   endtask

   task automatic load_x(input int wq[$], input bit gaps, input bit merge);
      foreach (wq[k]) begin
         if (k < NI) m_x[NI-1-k] = wq[k];
         put(wq[k], gaps, merge && (k == wq.size()-1));
      end
      if (!(merge && wq.size() > 0)) pulse_changes();
   endtask

   task automatic load_w(input int wq[$], input bit gaps, input bit merge);
      int n, f;
      foreach (wq[k]) begin
         if (k < NWORDS) begin
            n = NN - 1 - k / (NI+2);
            f = k % (NI+2);
            if (f == 0)      m_th[n] = wq[k];
            else if (f == 1) m_b[n]  = wq[k];
            else             m_w[n][NI+1-f] = wq[k];
         end
         put(wq[k], gaps, merge && (k == wq.size()-1));
      end
      if (!(merge && wq.size() > 0)) pulse_changes();
   endtask

   task automatic build_uniform_w(input int th0);
      q.delete();
      for (int n = NN-1; n >= 0; n--) begin
         q.push_back(n == 0 ? th0 : 0);
         q.push_back(n + 1);
         for (int i = 0; i < NI; i++) q.push_back(n + 1);
      end
   endtask

   // Called right after the edge that samples changes in LOAD_W.
   task automatic run_and_check(input string tag, input bit noise);
      logic [NN-1:0]    e_fo;
      logic [NN*DW-1:0] e_ro;
      int cnt;
      model_eval(e_fo, e_ro);
      cnt = 0;
      while (cnt < LAT + 20 && out_valid !== 1'b1) begin
         if (noise && cnt < LAT - 1) begin
            changes    = 1'($urandom);
            data_valid = 1'($urandom);
            data_in    = DW'($urandom);
         end else begin
            changes    = 1'b0;
            data_valid = 1'b0;
         end
         tick();
         cnt++;
         if (cnt == 1) chk({tag, "_busy"}, 64'(busy), 64'(1));
      end
      changes    = 1'b0;
      data_valid = 1'b0;
      chk({tag, "_lat"}, 64'(cnt), 64'(LAT));
      chk({tag, "_fo"}, 64'(final_output), 64'(e_fo));
      chk({tag, "_idle"}, 64'(busy), 64'(0));
`ifdef RELU_EN
      chk({tag, "_relu"}, 64'(relu_out), 64'(e_ro));
`endif
      tick();
      chk({tag, "_pulse"}, 64'(out_valid), 64'(0));
      chk({tag, "_hold"}, 64'(final_output), 64'(e_fo));
   endtask

   initial begin
      int gaps, merge, noise, nx, nw, mode, f, cnt;
      reset = 1'b1; data_valid = 1'b0; changes = 1'b0; data_in = '0;
      reset2 = 1'b1; dv2 = 1'b0; ch2 = 1'b0; din2 = '0;
      model_clear();
      repeat (3) tick();
      chk("rst_fo", 64'(final_output), 64'(0));
      chk("rst_ov", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      reset = 1'b0;
      tick();

      q = '{10, 9, 8, 7};
      load_x(q, 0, 0);
      build_uniform_w(0);
      load_w(q, 0, 0);
      run_and_check("base", 0);
      chk("base_const", 64'(final_output), 64'(4'b1111));
`ifdef RELU_EN
      chk("base_relu_const", 64'(relu_out), 64'({8'd140, 8'd105, 8'd70, 8'd35}));
`endif

      q.delete();
      load_x(q, 0, 0);
      build_uniform_w(36);
      load_w(q, 0, 0);
      run_and_check("th36", 0);
      chk("th36_const", 64'(final_output), 64'(4'b1110));

      q.delete();
      load_x(q, 0, 0);
      build_uniform_w(34);
      load_w(q, 0, 1);
      run_and_check("th34", 0);
      chk("th34_const", 64'(final_output), 64'(4'b1111));

      q = '{255, 255, 255, 255};
      load_x(q, 0, 0);
      q.delete();
      load_w(q, 0, 0);
      run_and_check("inonly", 0);
`ifdef RELU_EN
      chk("inonly_sat3", 64'(relu_out[31:24]), 64'(255));
`endif

      q = '{1, 2, 3, 4, 5, 6};
      load_x(q, 1, 0);
      q.delete();
      load_w(q, 0, 0);
      run_and_check("extra", 1);

      q = '{3, 3, 3, 3};
      load_x(q, 0, 0);
      build_uniform_w(0);
      load_w(q, 0, 0);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_clear();
      chk("abort_fo", 64'(final_output), 64'(0));
      chk("abort_ov", 64'(out_valid), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      cnt = 0;
      repeat (40) begin
         tick();
         if (out_valid === 1'b1) cnt++;
      end
      chk("abort_nopulse", 64'(cnt), 64'(0));
      q = '{10, 9, 8, 7};
      load_x(q, 0, 0);
      build_uniform_w(0);
      load_w(q, 0, 0);
      run_and_check("reload", 0);
      chk("reload_const", 64'(final_output), 64'(4'b1111));

      for (int it = 0; it < 10; it++) begin
         gaps  = int'($urandom_range(0, 1));
         merge = int'($urandom_range(0, 1));
         noise = int'($urandom_range(0, 1));
         q.delete();
         nx = NI - 1 + int'($urandom_range(0, 3));
         repeat (nx) q.push_back(int'($urandom_range(0, 7)));
         load_x(q, gaps[0], merge[0]);
         q.delete();
         mode = int'($urandom_range(0, 3));
         nw = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(1, NWORDS-1))
                                            : NWORDS + int'($urandom_range(0, 3));
         for (int k = 0; k < nw; k++) begin
            f = k % (NI+2);
            q.push_back(f == 0 ? int'($urandom_range(0, 255)) :
                        f == 1 ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)));
         end
         load_w(q, gaps[0], merge[0]);
         run_and_check($sformatf("rnd%0d", it), noise[0]);
      end

      reset = 1'b1;
      reset2 = 1'b0;
      tick();
      dv2 = 1'b1; din2 = 4'd15;
      repeat (3) tick();
      dv2 = 1'b0; ch2 = 1'b1;
      tick();
      ch2 = 1'b0; dv2 = 1'b1;
      repeat (10) tick();
      dv2 = 1'b0; ch2 = 1'b1;
      tick();
      ch2 = 1'b0;
      cnt = 0;
      while (cnt < 40 && ov2 !== 1'b1) begin
         tick();
         cnt++;
      end
      chk("p_lat", 64'(cnt), 64'(11));
      chk("p_fo", 64'(fo2), 64'(2'b11));
`ifdef RELU_EN
      chk("p_relu", 64'(relu2), 64'(8'hFF));
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
